// File: rtl/move_collector_pkg.sv
// Shared types and widths for the board-side move collector and its FIFO.
package move_collector_pkg;

    localparam int MOVE_W  = 16;
    localparam int PIECE_W = 10;
    localparam int NUM_SQ  = 64;
    localparam int BOARD_W = NUM_SQ * PIECE_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GEN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == ST_LOAD) || (s == ST_GEN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/move_collector_fifo.sv
// First-word fall-through FIFO buffering popped moves toward the search engine.
module move_fifo
    import move_collector_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = MOVE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/move_collector.sv
// Loads a position into the board, runs move generation, then drains the
// arbiter one move per pop into a FIFO that streams to the search engine.
module move_collector
    import move_collector_pkg::*;
#(
    parameter int COLLECT_CYCLES = 16,
    parameter int DEPTH          = 256,
    parameter int CNT_W          = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BOARD_W-1:0] board_in,
    input  logic               turn_in,
    output logic [BOARD_W-1:0] original_pieces,
    output logic               turn,
    output logic               new_original,
    output logic               collect_pieces,
    output logic               move_order,
    input  logic [MOVE_W-1:0]  best_move,
    input  logic [NUM_SQ-1:0]  stack_empty,
    output logic [MOVE_W-1:0]  move_data,
    output logic               move_valid,
    input  logic               move_ready,
    output logic [CNT_W-1:0]   move_count,
    output logic               busy,
    output logic               done
);

    localparam int                GEN_W    = (COLLECT_CYCLES > 1) ? $clog2(COLLECT_CYCLES) : 1;
    localparam logic [GEN_W-1:0]  GEN_LAST = GEN_W'(COLLECT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEPTH);

    state_e             state_q, state_d;
    logic [GEN_W-1:0]   gen_cnt_q, gen_cnt_d;
    logic               settle_q, settle_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               new_original_q, collect_q;
    logic [BOARD_W-1:0] board_q;
    logic               turn_q;

    logic all_empty, fifo_full, fifo_empty, flush, pop_c;

    assign all_empty = &stack_empty;

    always_comb begin
        state_d    = state_q;
        gen_cnt_d  = gen_cnt_q;
        settle_d   = 1'b0;
        count_d    = count_q;
        flush      = 1'b0;
        pop_c      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    flush   = 1'b1;
                    count_d = '0;
                end
            end
            ST_LOAD: begin
                state_d   = ST_GEN;
                gen_cnt_d = GEN_LAST;
            end
            ST_GEN: begin
                if (gen_cnt_q == '0) begin
                    state_d  = ST_DRAIN;
                    settle_d = 1'b1;
                end else begin
                    gen_cnt_d = gen_cnt_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                // A pop is only issued when the FIFO can take the word the same cycle.
                pop_c = !settle_q && !all_empty && !fifo_full;
                if (pop_c && (count_q != CNT_MAX)) count_d = count_q + 1'b1;
                if (!settle_q && all_empty) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            gen_cnt_q      <= '0;
            settle_q       <= 1'b0;
            count_q        <= '0;
            new_original_q <= 1'b0;
            collect_q      <= 1'b0;
            board_q        <= '0;
            turn_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gen_cnt_q      <= gen_cnt_d;
            settle_q       <= settle_d;
            count_q        <= count_d;
            new_original_q <= (state_d == ST_LOAD);
            collect_q      <= (state_d == ST_GEN);
            if (flush) begin
                board_q <= board_in;
                turn_q  <= turn_in;
            end
        end
    end

    move_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MOVE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (pop_c),
        .data_i  (best_move),
        .pop_i   (move_valid && move_ready),
        .data_o  (move_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign original_pieces = board_q;
    assign turn            = turn_q;
    assign new_original    = new_original_q;
    assign collect_pieces  = collect_q;
    assign move_order      = pop_c;
    assign move_valid      = !fifo_empty;
    assign move_count      = count_q;
    assign busy            = is_busy(state_q);
    assign done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_move_collector.sv
// Bench for move_collector: a queue-based board model feeds moves, and each
// position is checked against pulse counts, word order and the capped count.
module tb_move_collector;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int NCOL  = 16;

    logic         clk, rst, start, turn_in, turn;
    logic [639:0] board_in, original_pieces;
    logic         new_original, collect_pieces, move_order;
    logic [15:0]  best_move, move_data;
    logic [63:0]  stack_empty;
    logic         move_valid, move_ready, busy, done;
    logic [CNT_W-1:0] move_count;

    move_collector #(.COLLECT_CYCLES(NCOL), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .board_in(board_in), .turn_in(turn_in),
        .original_pieces(original_pieces), .turn(turn), .new_original(new_original),
        .collect_pieces(collect_pieces), .move_order(move_order), .best_move(best_move),
        .stack_empty(stack_empty), .move_data(move_data), .move_valid(move_valid),
        .move_ready(move_ready), .move_count(move_count), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0, failures = 0;
    int cyc = 0, nop_cnt = 0, col_cnt = 0, mo_cnt = 0, mv_cnt = 0;
    int mo_cyc[$];
    logic [15:0] rx[$];
    logic pop_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) pop_pend <= 1'b0;
        else     pop_pend <= move_order;
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            nop_cnt += int'(new_original);
            col_cnt += int'(collect_pieces);
            mv_cnt  += int'(move_valid);
            if (move_order) begin
                mo_cnt++;
                mo_cyc.push_back(cyc);
            end
            if (move_valid && move_ready) rx.push_back(move_data);
        end
    end

    logic [15:0]  board_q[$];
    logic [15:0]  exp_q[$];
    logic [639:0] exp_board;
    logic         exp_turn;
    logic         rand_ready = 1'b0;
    int base_nop, base_col, base_mo, base_mv, base_rx, base_mocyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_board();
        if (board_q.size() == 0) begin
            stack_empty = '1;
            best_move   = 16'($urandom);
        end else begin
            stack_empty = {$urandom, $urandom} & ~(64'd1 << $urandom_range(0, 63));
            best_move   = board_q[0];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (pop_pend && board_q.size() > 0) void'(board_q.pop_front());
        drive_board();
        if (rand_ready) move_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_pos();
        board_q = exp_q;
        for (int k = 0; k < 20; k++) exp_board[32*k +: 32] = $urandom;
        board_in = exp_board;
        turn_in  = 1'($urandom);
        exp_turn = turn_in;
        drive_board();
        base_nop = nop_cnt; base_col = col_cnt; base_mo = mo_cnt; base_mv = mv_cnt;
        base_rx = rx.size(); base_mocyc = mo_cyc.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("orig_latched", 64'(original_pieces === exp_board), 64'd1);
        check("turn_latched", 64'(turn), 64'(exp_turn));
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!done && i < budget) begin tick(); i++; end
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic wait_drained(input int budget);
        int i = 0;
        while (move_valid && i < budget) begin tick(); i++; end
        check("fifo_drained", 64'(move_valid), 64'd0);
    endtask

    task automatic wait_pops(input int n, input int budget);
        int i = 0;
        while ((mo_cnt - base_mo) < n && i < budget) begin tick(); i++; end
        check("pops_reached", 64'(mo_cnt - base_mo), 64'(n));
    endtask

    task automatic check_position(input int n);
        int got;
        check("new_original_pulses", 64'(nop_cnt - base_nop), 64'd1);
        check("collect_cycles", 64'(col_cnt - base_col), 64'(NCOL));
        check("move_order_pulses", 64'(mo_cnt - base_mo), 64'(n));
        check("move_count", 64'(move_count), 64'((n > DEPTH) ? DEPTH : n));
        got = rx.size() - base_rx;
        check("rx_words", 64'(got), 64'(n));
        for (int i = 0; i < n && i < got; i++) check("rx_data", 64'(rx[base_rx + i]), 64'(exp_q[i]));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; board_in = '0; turn_in = 1'b0;
        move_ready = 1'b0; best_move = '0; stack_empty = '1;
        #23;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_move_order", 64'(move_order), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", 64'({original_pieces != '0, turn, new_original, collect_pieces,
                                    move_order, move_valid, busy, done}), 64'd0);
        check("reset_count", 64'(move_count), 64'd0);

        // Basic drain of three fixed moves.
        exp_q = '{16'h1234, 16'h0F00, 16'h0001};
        move_ready = 1'b1;
        start_pos();
        wait_done(200);
        wait_drained(50);
        check_position(3);
        if (mo_cyc.size() - base_mocyc == 3)
            check("pops_consecutive", 64'(mo_cyc[base_mocyc + 2] - mo_cyc[base_mocyc]), 64'd2);
        check("busy_in_done", 64'(busy), 64'd0);

        // Empty position.
        exp_q = {};
        start_pos();
        wait_done(200);
        check_position(0);
        check("empty_valid_never", 64'(mv_cnt - base_mv), 64'd0);

        // Backpressure: FIFO fills at DEPTH, then resumes once the consumer reads.
        exp_q = {};
        for (int i = 0; i < 6; i++) exp_q.push_back(16'($urandom));
        move_ready = 1'b0;
        start_pos();
        wait_pops(DEPTH, 200);
        repeat (6) tick();
        check("stall_pops", 64'(mo_cnt - base_mo), 64'(DEPTH));
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_valid", 64'(move_valid), 64'd1);
        move_ready = 1'b1;
        wait_done(200);
        wait_drained(50);
        check_position(6);

        // Start ignored during GEN and DRAIN.
        exp_q = {};
        for (int i = 0; i < 5; i++) exp_q.push_back(16'($urandom));
        move_ready = 1'b0;
        start_pos();
        repeat (4) tick();
        check("in_gen", 64'(collect_pieces), 64'd1);
        start = 1'b1; tick(); start = 1'b0;
        wait_pops(DEPTH, 200);
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        check("ignored_busy", 64'(busy), 64'd1);
        check("ignored_new_original", 64'(nop_cnt - base_nop), 64'd1);
        move_ready = 1'b1;
        wait_done(200);
        wait_drained(50);
        check_position(5);

        // Asynchronous reset while stalled in DRAIN.
        exp_q = {};
        for (int i = 0; i < 6; i++) exp_q.push_back(16'($urandom));
        move_ready = 1'b0;
        start_pos();
        wait_pops(DEPTH, 200);
        #2 rst = 1'b1;
        #1;
        check("arst_move_order", 64'(move_order), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(move_valid), 64'd0);
        check("arst_count", 64'(move_count), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check("post_rst_idle", 64'({busy, done}), 64'd0);

        // Restart from DONE with two unread words still buffered.
        exp_q = '{16'hAAAA, 16'h5555};
        move_ready = 1'b0;
        start_pos();
        wait_done(200);
        check("unread_valid", 64'(move_valid), 64'd1);
        check("unread_count", 64'(move_count), 64'd2);
        exp_q = '{16'hBEEF, 16'h0102, 16'hC0DE};
        start_pos();
        check("restart_flushed", 64'(move_valid), 64'd0);
        check("restart_count", 64'(move_count), 64'd0);
        move_ready = 1'b1;
        wait_done(200);
        wait_drained(50);
        check_position(3);

        // Randomised positions with a randomly stalling consumer.
        for (int p = 0; p < 6; p++) begin
            int n;
            n = $urandom_range(0, 7);
            exp_q = {};
            for (int i = 0; i < n; i++) exp_q.push_back(16'($urandom));
            rand_ready = 1'b1;
            start_pos();
            wait_done(400);
            rand_ready = 1'b0;
            move_ready = 1'b1;
            wait_drained(50);
            check_position(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
